// File: rtl/hwpe_stream_demux_burst_if.sv
// Valid/ready stream bundle with data and byte strobes.
// master drives the beat, slave returns ready.
interface hwpe_stream_demux_burst_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport master (
      output valid, data, strb,
      input  ready
   );

   modport slave (
      input  valid, data, strb,
      output ready
   );
endinterface

// File: rtl/hwpe_stream_demux_burst.sv
// Burst-framed 1-to-N stream demux: one command routes len beats to one output.
// HWPE_STREAM_DEMUX_BURST_REG_EN adds a register slice on every output.
module hwpe_stream_demux_burst #(
   parameter int unsigned NB_OUT_STREAMS = 4,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned LEN_WIDTH      = 16,
   localparam int unsigned SEL_WIDTH     = $clog2(NB_OUT_STREAMS)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [SEL_WIDTH-1:0] cmd_sel_i,
   input  logic [LEN_WIDTH-1:0] cmd_len_i,
   hwpe_stream_demux_burst_if.slave  push_i,
   hwpe_stream_demux_burst_if.master pop_o [NB_OUT_STREAMS],
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE,
      ROUTE,
      DROP,
      DRAIN
   } state_e;

   state_e state_q, state_d;

   logic [LEN_WIDTH-1:0] cnt_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic [SEL_WIDTH-1:0] sel_q;

   logic done_q, done_d;
   logic err_q, err_d;

   logic cmd_hs;
   logic push_hs;
   logic push_ready;
   logic last_beat;
   logic sel_ok;

   logic [NB_OUT_STREAMS-1:0] pop_ready;

`ifdef HWPE_STREAM_DEMUX_BURST_REG_EN
   logic [NB_OUT_STREAMS-1:0] slice_full;
   logic                      drain_hs;

   assign drain_hs = slice_full[sel_q] & pop_ready[sel_q];
`endif

   assign cmd_hs      = cmd_valid_i & cmd_ready_o;
   assign push_hs     = push_i.valid & push_ready;
   assign push_i.ready = push_ready;
   assign last_beat   = (cnt_q == len_q - LEN_WIDTH'(1));
   assign sel_ok      = 32'(cmd_sel_i) < NB_OUT_STREAMS;

   assign done_o = done_q;
   assign err_o  = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_hs) begin
               if (!sel_ok) err_d = 1'b1;
               if (cmd_len_i == '0) done_d = 1'b1;
               else if (sel_ok) state_d = ROUTE;
               else state_d = DROP;
            end
         end
         ROUTE: begin
            if (push_hs && last_beat) begin
`ifdef HWPE_STREAM_DEMUX_BURST_REG_EN
               state_d = DRAIN;
`else
               state_d = IDLE;
               done_d  = 1'b1;
`endif
            end
         end
         DROP: begin
            if (push_hs && last_beat) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         DRAIN: begin
`ifdef HWPE_STREAM_DEMUX_BURST_REG_EN
            // last beat must leave its slice before completion
            if (drain_hs) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
      if (clear_i) begin
         state_d = IDLE;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_comb begin
      cmd_ready_o = 1'b0;
      busy_o      = 1'b1;
      push_ready  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            busy_o      = 1'b0;
         end
         ROUTE: begin
`ifdef HWPE_STREAM_DEMUX_BURST_REG_EN
            push_ready = ~slice_full[sel_q] | pop_ready[sel_q];
`else
            push_ready = pop_ready[sel_q];
`endif
         end
         DROP:    push_ready = 1'b1;
         default: push_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         len_q <= '0;
         sel_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (cmd_hs) begin
         cnt_q <= '0;
         len_q <= cmd_len_i;
         sel_q <= cmd_sel_i;
      end else if (push_hs) begin
         cnt_q <= cnt_q + LEN_WIDTH'(1);
      end
   end

   for (genvar i = 0; i < NB_OUT_STREAMS; i++) begin : g_pop
      logic hit;

      assign hit          = (state_q == ROUTE) && (sel_q == SEL_WIDTH'(i));
      assign pop_ready[i] = pop_o[i].ready;

`ifdef HWPE_STREAM_DEMUX_BURST_REG_EN
      logic                  full_q;
      logic [DATA_WIDTH-1:0] data_q;
      logic [STRB_WIDTH-1:0] strb_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
            strb_q <= '0;
         end else if (clear_i) begin
            full_q <= 1'b0;
         end else if (hit && push_hs) begin
            full_q <= 1'b1;
            data_q <= push_i.data;
            strb_q <= push_i.strb;
         end else if (pop_ready[i]) begin
            full_q <= 1'b0;
         end
      end

      assign slice_full[i] = full_q;
      assign pop_o[i].valid = full_q;
      assign pop_o[i].data  = full_q ? data_q : '0;
      assign pop_o[i].strb  = full_q ? strb_q : '0;
`else
      assign pop_o[i].valid = hit & push_i.valid;
      assign pop_o[i].data  = hit ? push_i.data : '0;
      assign pop_o[i].strb  = hit ? push_i.strb : '0;
`endif
   end

endmodule

// File: tb/tb_hwpe_stream_demux_burst.sv
// Directed bench for hwpe_stream_demux_burst (combinational build).
// Five outputs so that sel=5 is a representable bad select.
module tb_hwpe_stream_demux_burst;

   localparam int NB = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        cmd_valid;
   logic [2:0]  cmd_sel;
   logic [15:0] cmd_len;
   logic        cmd_ready;
   logic        busy;
   logic        done;
   logic        err;

   int n_chk = 0;
   int n_err = 0;

   logic [NB-1:0] pop_rdy;
   logic [NB-1:0] pop_val;
   logic [31:0]   pop_dat [NB];
   logic [3:0]    pop_stb [NB];

   hwpe_stream_demux_burst_if #(.DATA_WIDTH(32)) push ();
   hwpe_stream_demux_burst_if #(.DATA_WIDTH(32)) pop [NB] ();

   for (genvar i = 0; i < NB; i++) begin : g_pop
      assign pop[i].ready = pop_rdy[i];
      assign pop_val[i]   = pop[i].valid;
      assign pop_dat[i]   = pop[i].data;
      assign pop_stb[i]   = pop[i].strb;
   end

   hwpe_stream_demux_burst #(
      .NB_OUT_STREAMS(NB),
      .DATA_WIDTH(32),
      .LEN_WIDTH(16)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .clear_i(clear),
      .cmd_valid_i(cmd_valid),
      .cmd_ready_o(cmd_ready),
      .cmd_sel_i(cmd_sel),
      .cmd_len_i(cmd_len),
      .push_i(push),
      .pop_o(pop),
      .busy_o(busy),
      .done_o(done),
      .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(logic [2:0] s, logic [15:0] l);
      cmd_valid = 1'b1;
      cmd_sel   = s;
      cmd_len   = l;
      #1;
      check("cmd_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic push_beat(logic [31:0] d, logic [NB-1:0] ev, int s);
      push.valid = 1'b1;
      push.data  = d;
      push.strb  = 4'hF;
      #1;
      check("beat_rdy", push.ready, 1);
      check("beat_val", pop_val, ev);
      if (s < NB) check("beat_dat", pop_dat[s], d);
      tick();
      push.valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1);
   end

   initial begin
      int idx;
      int k;
      rst_n      = 1'b0;
      clear      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_sel    = '0;
      cmd_len    = '0;
      push.valid = 1'b0;
      push.data  = '0;
      push.strb  = '0;
      pop_rdy    = '1;

      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_push_rdy", push.ready, 0);
      check("rst_pop_val", pop_val, 0);
      rst_n = 1'b1;
      tick();

      // 1: sel=2 len=4 all ready
      send_cmd(3'd2, 16'd4);
      check("t1_busy", busy, 1);
      for (int i = 0; i < 4; i++)
         push_beat(32'hA0 + 32'(i), 5'b00100, 2);
      #1;
      check("t1_done", done, 1);
      check("t1_busy_low", busy, 0);
      check("t1_push_rdy", push.ready, 0);
      tick();
      check("t1_done_clr", done, 0);

      // 2: pop ready toggles 1010
      send_cmd(3'd2, 16'd4);
      idx = 0;
      k   = 0;
      while (idx < 4 && k < 16) begin
         pop_rdy[2] = (k % 2 == 0);
         push.valid = 1'b1;
         push.data  = 32'hA0 + 32'(idx);
         push.strb  = 4'h5;
         #1;
         check("t2_push_rdy", push.ready, (k % 2 == 0) ? 1 : 0);
         check("t2_val", pop_val, 5'b00100);
         check("t2_data", pop_dat[2], 32'hA0 + 32'(idx));
         check("t2_strb", pop_stb[2], 4'h5);
         if (k % 2 == 0) idx++;
         tick();
         k++;
      end
      check("t2_beats", idx, 4);
      check("t2_cycles", k, 7);
      push.valid = 1'b0;
      pop_rdy    = '1;
      #1;
      check("t2_done", done, 1);
      tick();
      check("t2_done_clr", done, 0);

      // 3: bad select drops beats
      send_cmd(3'd5, 16'd3);
      check("t3_err", err, 1);
      check("t3_busy", busy, 1);
      for (int i = 0; i < 3; i++)
         push_beat(32'hF0 + 32'(i), 5'b00000, NB);
      #1;
      check("t3_done", done, 1);
      check("t3_busy_low", busy, 0);
      tick();
      check("t3_done_clr", done, 0);
      check("t3_err_sticky", err, 1);

      // 4: zero-length command
      send_cmd(3'd1, 16'd0);
      push.valid = 1'b1;
      #1;
      check("t4_done", done, 1);
      check("t4_busy", busy, 0);
      check("t4_push_rdy", push.ready, 0);
      check("t4_pop_val", pop_val, 0);
      push.valid = 1'b0;
      tick();
      check("t4_done_clr", done, 0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("t4_err_clr", err, 0);

      // 5: clear after 2 of 8 beats
      send_cmd(3'd3, 16'd8);
      push_beat(32'hC0, 5'b01000, 3);
      push_beat(32'hC1, 5'b01000, 3);
      clear      = 1'b1;
      push.valid = 1'b1;
      push.data  = 32'hC2;
      #1;
      check("t5_inflight_val", pop_val, 5'b01000);
      check("t5_inflight_dat", pop_dat[3], 32'hC2);
      tick();
      clear      = 1'b0;
      push.valid = 1'b0;
      check("t5_busy", busy, 0);
      check("t5_cmd_ready", cmd_ready, 1);
      check("t5_no_done", done, 0);
      tick();
      check("t5_no_done2", done, 0);
      send_cmd(3'd1, 16'd2);
      push_beat(32'hD0, 5'b00010, 1);
      push_beat(32'hD1, 5'b00010, 1);
      #1;
      check("t5_done", done, 1);
      tick();

      // 6: async reset mid-burst
      send_cmd(3'd0, 16'd4);
      push_beat(32'hE0, 5'b00001, 0);
      push.valid = 1'b1;
      push.data  = 32'hE1;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_push_rdy", push.ready, 0);
      check("t6_pop_val", pop_val, 0);
      check("t6_cmd_ready", cmd_ready, 1);
      check("t6_done", done, 0);
      tick();
      push.valid = 1'b0;
      rst_n      = 1'b1;
      tick();
      check("t6_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
